reg_native_if2mem_mc: RTL
=========================

REG_NATIVE_IF2MEM_MC -- requirements
Module: reg_native_if2mem_mc

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- BUS_DATA_WIDTH, 32, native bus data width.
- BUS_ADDR_WIDTH, 64, native byte-address width.
- MEM_DATA_WIDTH, 64, memory entry width; an integer multiple (BEATS >= 1) of BUS_DATA_WIDTH.
- MEM_ADDR_WIDTH, 5, entry-index width per memory.
- MEM_NUM, 2, number of downstream memory channels.
- TIMEOUT_CYCLES, 255, maximum wait for mem_ack.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- native_clk, in, 1, clock.
- native_rst_n, in, 1, reset.
- soft_rst, in, 1, synchronous clear.
- req_vld, in, 1, request pulse.
- ack_vld, out, 1, response pulse.
- err, out, 1, response error; valid with ack_vld.
- addr, in, BUS_ADDR_WIDTH, byte address.
- wr_en, in, 1, write.
- rd_en, in, 1, read.
- wr_data, in, BUS_DATA_WIDTH, write data.
- rd_data, out, BUS_DATA_WIDTH, read data.
- mem_req_vld, out, MEM_NUM, per-channel request.
- mem_ack_vld, in, MEM_NUM, per-channel ack.
- mem_addr, out, MEM_ADDR_WIDTH, shared entry index.
- mem_wr_en, out, 1, shared write enable.
- mem_rd_en, out, 1, shared read enable.
- mem_wr_data, out, MEM_DATA_WIDTH, shared write data.
- mem_rd_data, in, MEM_NUM*MEM_DATA_WIDTH, channel c occupies slice [c*MEM_DATA_WIDTH +: MEM_DATA_WIDTH].

REQ-003 Reset SHALL be native_rst_n, asynchronous, active-low; clock SHALL be native_clk.

Function
REQ-004 Address decode, LSB upward: byte offset log2(BUS_DATA_WIDTH/8), beat index log2(BEATS), entry MEM_ADDR_WIDTH, channel max(1,log2(MEM_NUM)); higher bits SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, MEM_WAIT and RESP; only IDLE accepts req_vld, and req_vld in any other state SHALL be dropped with no ack.
REQ-006 In IDLE, wr_en==rd_en or channel >= MEM_NUM SHALL give ack_vld=1, err=1, rd_data=0 one cycle later, with no memory access.
REQ-007 A write to beat < BEATS-1 SHALL store wr_data into the write snapshot at that beat and ack (err=0) one cycle later, with no memory access.
REQ-008 A write to beat BEATS-1 SHALL issue a memory write: mem_wr_data = {wr_data, snapshot beats BEATS-2..0}, mem_wr_en=1, mem_addr=entry.
REQ-009 A read of beat 0 SHALL issue a memory read (mem_rd_en=1).
REQ-010 A read of beat k>0 SHALL return read-snapshot beat k one cycle later, with no memory access.
REQ-011 Memory access: mem_req_vld[ch] SHALL assert the cycle after req_vld; mem_addr/wr_en/rd_en/wr_data SHALL be held stable until the selected channel's mem_ack_vld is sampled high; deassert in the next cycle.
REQ-012 On mem ack, read data SHALL load the full read snapshot, and the block SHALL enter RESP; ack_vld SHALL pulse one cycle after the mem ack with rd_data = beat 0 (reads) or 0 (writes), err=0.
REQ-013 mem_ack_vld on non-selected channels, or outside MEM_WAIT, SHALL be ignored.
REQ-014 A timeout counter SHALL run in MEM_WAIT; at TIMEOUT_CYCLES without ack, mem_req_vld SHALL drop, ack_vld=1, err=1, rd_data=0, and the read snapshot SHALL be unchanged.
REQ-015 ack_vld and err SHALL be single-cycle pulses; rd_data SHALL be registered and held until the next ack.
REQ-016 BEATS==1 SHALL degenerate to a direct access per request, with no snapshot storage.

Reset
REQ-017 Asynchronous reset and soft_rst SHALL both force:
- state IDLE;
- all outputs 0;
- snapshots 0;
- timeout counter 0.
REQ-018 Reset or soft_rst during MEM_WAIT SHALL abandon the access with no ack; a late mem_ack SHALL be ignored.

Structure
REQ-019 Package reg_native_if2mem_pkg SHALL hold the FSM state enum and beat/channel index width helper functions.
REQ-020 Snapshot storage (write and read buffers) SHALL be one sub-module, mem_snapshot_buf.

Verification (BUS 32, MEM 64, MEM_NUM 2, MEM_ADDR_WIDTH 5, TIMEOUT_CYCLES 16)
REQ-021 Write 0x108=0x11111111, then 0x10C=0x22222222:
- first access acks next cycle, with no mem_req;
- then mem_req_vld=2'b10, mem_addr=1, mem_wr_data=0x22222222_11111111;
- after a mem ack at cycle +3, ack_vld follows one cycle later with err=0.
REQ-022 Read 0x108 with ch1 returning 0xAAAABBBB_CCCCDDDD:
- rd_data=0xCCCCDDDD;
- a following read 0x10C acks in 1 cycle with rd_data=0xAAAABBBB and no mem_req.
REQ-023 Read 0x008 with no mem ack: mem_req_vld drops after 16 cycles, with ack_vld=1, err=1, rd_data=0.
REQ-024 req_vld with wr_en=rd_en=1 -> err ack next cycle, mem_req_vld stays 0.
REQ-025 soft_rst during MEM_WAIT: outputs clear, and a mem_ack two cycles later produces no ack_vld.
REQ-026 A second req_vld issued during MEM_WAIT produces no ack, with the first access completing normally.

Source files
------------

// File: rtl/reg_native_if2mem_pkg.sv
// Shared types and index-width helpers for the native-bus to memory bridge.
package reg_native_if2mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_RESP
    } state_e;

    // Address bits consumed by the beat field; zero when an entry is one bus word.
    function automatic int beat_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 0;
    endfunction

    // Width of an index register; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_snapshot_buf.sv
// Write and read snapshot buffers that widen bus beats into memory entries.
module mem_snapshot_buf #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BEATS          = 2,
    parameter int BEAT_W         = 1
) (
    input  logic                      native_clk,
    input  logic                      native_rst_n,
    input  logic                      i_clr,
    input  logic                      i_wr_en,
    input  logic [BEAT_W-1:0]         i_wr_beat,
    input  logic [BUS_DATA_WIDTH-1:0] i_wr_data,
    output logic [MEM_DATA_WIDTH-1:0] o_wr_snap,
    input  logic                      i_rd_load,
    input  logic [MEM_DATA_WIDTH-1:0] i_rd_data,
    input  logic [BEAT_W-1:0]         i_rd_beat,
    output logic [BUS_DATA_WIDTH-1:0] o_rd_beat
);

    if (BEATS > 1) begin : g_store
        logic [MEM_DATA_WIDTH-1:0] r_wr_snap;
        logic [MEM_DATA_WIDTH-1:0] r_rd_snap;

        // NOTE: these buffers are reset on purpose -- a beat read before any fill must return 0.
        always_ff @(posedge native_clk or negedge native_rst_n) begin
            if (!native_rst_n) begin
                r_wr_snap <= '0;
                r_rd_snap <= '0;
            end else if (i_clr) begin
                r_wr_snap <= '0;
                r_rd_snap <= '0;
            end else begin
                if (i_wr_en)
                    r_wr_snap[int'(i_wr_beat)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= i_wr_data;
                if (i_rd_load)
                    r_rd_snap <= i_rd_data;
            end
        end

        assign o_wr_snap = r_wr_snap;
        assign o_rd_beat = r_rd_snap[int'(i_rd_beat)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end else begin : g_direct
        assign o_wr_snap = '0;
        assign o_rd_beat = '0;
    end

endmodule

// File: rtl/reg_native_if2mem_mc.sv
// Native register bus to multi-channel memory bridge: decodes byte addresses into
// channel/entry/beat and assembles bus beats into full-width memory accesses.
module reg_native_if2mem_mc
    import reg_native_if2mem_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 64,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int MEM_NUM        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              native_clk,
    input  logic                              native_rst_n,
    input  logic                              soft_rst,
    input  logic                              req_vld,
    output logic                              ack_vld,
    output logic                              err,
    input  logic [BUS_ADDR_WIDTH-1:0]         addr,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [BUS_DATA_WIDTH-1:0]         wr_data,
    output logic [BUS_DATA_WIDTH-1:0]         rd_data,
    output logic [MEM_NUM-1:0]                mem_req_vld,
    input  logic [MEM_NUM-1:0]                mem_ack_vld,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
    output logic                              mem_wr_en,
    output logic                              mem_rd_en,
    output logic [MEM_DATA_WIDTH-1:0]         mem_wr_data,
    input  logic [MEM_NUM*MEM_DATA_WIDTH-1:0] mem_rd_data
);

    localparam int BEATS     = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
    localparam int OFF_W     = $clog2(BUS_DATA_WIDTH / 8);
    localparam int BEAT_BITS = beat_bits(BEATS);
    localparam int BEAT_W    = idx_width(BEATS);
    localparam int CHAN_W    = idx_width(MEM_NUM);
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MEM_DATA_WIDTH-1:0] LOW_MASK = {MEM_DATA_WIDTH{1'b1}} >> BUS_DATA_WIDTH;

    state_e              r_state;
    logic [CHAN_W-1:0]   r_ch;
    logic [CNT_W-1:0]    r_cnt;

    logic [BUS_ADDR_WIDTH-1:0] w_sh_beat, w_sh_entry, w_sh_chan;
    logic [BEAT_W-1:0]         w_beat;
    logic [MEM_ADDR_WIDTH-1:0] w_entry;
    logic [CHAN_W-1:0]         w_chan;
    logic                      w_chan_bad, w_last, w_is_err, w_mem_go;
    logic                      w_wr_snap_en, w_rd_load, w_sel_ack;
    logic [MEM_DATA_WIDTH-1:0] w_wr_snap, w_wr_full, w_sel_rd;
    logic [BUS_DATA_WIDTH-1:0] w_rd_beat;

    assign w_sh_beat  = addr >> OFF_W;
    assign w_sh_entry = addr >> (OFF_W + BEAT_BITS);
    assign w_sh_chan  = addr >> (OFF_W + BEAT_BITS + MEM_ADDR_WIDTH);
    // Masking keeps the beat at zero when an entry is a single bus word.
    assign w_beat     = w_sh_beat[BEAT_W-1:0] & BEAT_W'(BEATS - 1);
    assign w_entry    = w_sh_entry[MEM_ADDR_WIDTH-1:0];
    assign w_chan     = w_sh_chan[CHAN_W-1:0];
    assign w_chan_bad = int'(w_chan) >= MEM_NUM;
    assign w_last     = (w_beat == BEAT_W'(BEATS - 1));
    assign w_is_err   = (wr_en == rd_en) || w_chan_bad;
    assign w_mem_go   = !w_is_err && ((wr_en && w_last) || (rd_en && w_beat == '0));

    assign w_wr_snap_en = (r_state == ST_IDLE) && req_vld && !w_is_err && wr_en && !w_last;
    assign w_sel_ack    = mem_ack_vld[r_ch];
    assign w_sel_rd     = mem_rd_data[int'(r_ch)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    assign w_rd_load    = (r_state == ST_MEM_WAIT) && w_sel_ack && mem_rd_en;
    assign w_wr_full    = (w_wr_snap & LOW_MASK) |
                          (MEM_DATA_WIDTH'(wr_data) << (MEM_DATA_WIDTH - BUS_DATA_WIDTH));

    mem_snapshot_buf #(
        .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
        .BEATS          (BEATS),
        .BEAT_W         (BEAT_W)
    ) u_snap (
        .native_clk   (native_clk),
        .native_rst_n (native_rst_n),
        .i_clr        (soft_rst),
        .i_wr_en      (w_wr_snap_en),
        .i_wr_beat    (w_beat),
        .i_wr_data    (wr_data),
        .o_wr_snap    (w_wr_snap),
        .i_rd_load    (w_rd_load),
        .i_rd_data    (w_sel_rd),
        .i_rd_beat    (w_beat),
        .o_rd_beat    (w_rd_beat)
    );

    always_ff @(posedge native_clk or negedge native_rst_n) begin
        // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
        if (!native_rst_n) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_cnt       <= '0;
            ack_vld     <= 1'b0;
            err         <= 1'b0;
            rd_data     <= '0;
            mem_req_vld <= '0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_data <= '0;
        end else if (soft_rst) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_cnt       <= '0;
            ack_vld     <= 1'b0;
            err         <= 1'b0;
            rd_data     <= '0;
            mem_req_vld <= '0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            ack_vld <= 1'b0;
            err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_vld) begin
                        if (w_mem_go) begin
                            r_state     <= ST_MEM_WAIT;
                            r_ch        <= w_chan;
                            r_cnt       <= '0;
                            mem_req_vld <= MEM_NUM'(1) << w_chan;
                            mem_addr    <= w_entry;
                            mem_wr_en   <= wr_en;
                            mem_rd_en   <= rd_en;
                            mem_wr_data <= wr_en ? w_wr_full : '0;
                        end else begin
                            r_state <= ST_RESP;
                            ack_vld <= 1'b1;
                            err     <= w_is_err;
                            rd_data <= (!w_is_err && rd_en) ? w_rd_beat : '0;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_sel_ack || r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state     <= ST_RESP;
                        mem_req_vld <= '0;
                        mem_wr_en   <= 1'b0;
                        mem_rd_en   <= 1'b0;
                        ack_vld     <= 1'b1;
                        err         <= !w_sel_ack;
                        rd_data     <= (w_sel_ack && mem_rd_en) ? w_sel_rd[BUS_DATA_WIDTH-1:0] : '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
